// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph table and decoder shared by the display controller and the scan decoder
package seven_seg_pkg;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    decode_glyph = '0;
    for (int i = 0; i < 16; i++)
      if (seg == GLYPHS[i]) decode_glyph = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/input_stabilizer.sv
// input_stabilizer: synchronizes a word and strobes commit once it has been stable for STABLE_CYCLES
module input_stabilizer #(
  parameter int W = 11,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic         commit
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [W-1:0] meta, sync, prev;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = sync == prev && cnt == CW'(STABLE_CYCLES - 1);
  // s captures the word with the strobe so a change on the next cycle cannot corrupt the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
      cnt <= '0;
      commit <= 1'b0;
      s <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
      cnt <= sync != prev ? '0 : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
      commit <= hit;
      if (hit) s <= sync;
    end
  end
endmodule

// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: recovers per-digit hex values from a scanned seven-segment bus
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          LED_in,
  input  logic [DIGITS-1:0]   anode_in,
  output logic [4*DIGITS-1:0] digit_value,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                frame_valid,
  output logic                seg_error,
  output logic                anode_error
);
  logic [DIGITS+6:0] s;
  logic commit, onehot, frame_n, seg_err_n, an_err_n;
  logic [DIGITS-1:0] anode, seen, seen_n, vld_n;
  logic [6:0] seg;
  logic [4:0] dec;
  logic [4*DIGITS-1:0] val_n;
  input_stabilizer #(.W(DIGITS + 7), .STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .clk(clk), .rst_n(rst_n), .d({anode_in, LED_in}), .s(s), .commit(commit)
  );
  assign anode = s[DIGITS+6:7];
  assign seg = s[6:0];
  always_comb begin
    dec = decode_glyph(seg);
    onehot = anode != '0 && (anode & (anode - DIGITS'(1))) == '0;
    val_n = digit_value;
    vld_n = digit_valid;
    seen_n = seen;
    if (commit && onehot) begin
      seen_n = seen | anode;
      for (int i = 0; i < DIGITS; i++)
        if (anode[i]) begin
          vld_n[i] = dec[4];
          if (dec[4]) val_n[4*i +: 4] = dec[3:0];
        end
    end
    frame_n = commit && onehot && &seen_n;
    seg_err_n = commit && onehot && !dec[4] && seg != BLANK;
    an_err_n = commit && anode != '0 && !onehot;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_value <= '0;
      digit_valid <= '0;
      seen <= '0;
      frame_valid <= 1'b0;
      seg_error <= 1'b0;
      anode_error <= 1'b0;
    end else begin
      digit_value <= val_n;
      digit_valid <= vld_n;
      seen <= frame_n ? '0 : seen_n;
      frame_valid <= frame_n;
      seg_error <= seg_err_n;
      anode_error <= an_err_n;
    end
  end
endmodule
